flag_writeback_stage: RTL

FLAG_WRITEBACK_STAGE -- requirements
Module: flag_writeback_stage

---
 rtl/flag_writeback_stage_if.sv | 31 +++
 rtl/flag_writeback_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/flag_writeback_stage_if.sv
// Bus between the ALU stage, the flag/writeback stage and the register file.
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1; valid never waits on ready.
interface flag_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_carry;
  logic [1:0]  in_cond;
  logic        in_wr_c;
  logic        in_wr_z;
  logic        in_rd_we;
  logic [2:0]  in_rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd_addr;
  logic        out_rd_we;

  modport master (
    output in_valid, in_result, in_carry, in_cond, in_wr_c, in_wr_z,
           in_rd_we, in_rd_addr, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd_addr, out_rd_we
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_cond, in_wr_c, in_wr_z,
           in_rd_we, in_rd_addr, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd_addr, out_rd_we
  );
endinterface

// File: rtl/flag_writeback_stage.sv
// Final pipeline stage: evaluates the condition code, updates C/Z, and holds
// one writeback entry for the register file, with retire/squash statistics.
module flag_writeback_stage (
  input  logic                         clk,
  input  logic                         rst_n,
  flag_writeback_stage_if.slave        bus,
  output logic                         c_flag,
  output logic                         z_flag,
  output logic [15:0]                  retired_cnt,
  output logic [15:0]                  squashed_cnt,
  output logic                         o_dbg_state
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_result;
  logic [2:0]  r_rd_addr;
  logic        r_rd_we;
  logic        r_flag_upd;
  logic        r_c;
  logic        r_z;
  logic [15:0] r_retired;
  logic [15:0] r_squashed;

  logic        w_full;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_pass;
  logic        w_drain;
  logic        w_retire;
  logic [1:0]  w_sq_inc;

  assign w_full     = (r_state == ST_FULL);
  assign w_in_ready = rst_n & (~w_full | bus.out_ready) & ~bus.flush;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Condition is judged against the flags as they stand before this edge.
  always_comb begin
    w_pass = 1'b0;
    case (bus.in_cond)
      2'b00:   w_pass = 1'b1;
      2'b01:   w_pass = r_z;
      2'b10:   w_pass = r_c;
      default: w_pass = 1'b0;
    endcase
  end

  assign w_drain  = w_full & bus.out_ready & ~bus.flush;
  assign w_retire = w_drain & (r_rd_we | r_flag_upd);
  assign w_sq_inc = {1'b0, w_accept & ~w_pass} + {1'b0, bus.flush & w_full};

  always_comb begin
    w_next_state = r_state;
    if (bus.flush)
      w_next_state = ST_EMPTY;
    else if (w_accept)
      w_next_state = ST_FULL;
    else if (w_drain)
      w_next_state = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_EMPTY;
    else
      r_state <= w_next_state;
  end

  // Failed-condition entries still occupy the slot so writeback order is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result   <= 16'h0000;
      r_rd_addr  <= 3'd0;
      r_rd_we    <= 1'b0;
      r_flag_upd <= 1'b0;
      r_c        <= 1'b0;
      r_z        <= 1'b0;
      r_retired  <= 16'h0000;
      r_squashed <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_result   <= bus.in_result;
        r_rd_addr  <= bus.in_rd_addr;
        r_rd_we    <= w_pass & bus.in_rd_we;
        r_flag_upd <= w_pass & (bus.in_wr_c | bus.in_wr_z);
        if (w_pass && bus.in_wr_c)
          r_c <= bus.in_carry;
        if (w_pass && bus.in_wr_z)
          r_z <= (bus.in_result == 16'h0000);
      end
      if (w_retire)
        r_retired <= r_retired + 16'd1;
      r_squashed <= r_squashed + {14'd0, w_sq_inc};
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_full;
  assign bus.out_result  = r_result;
  assign bus.out_rd_addr = r_rd_addr;
  assign bus.out_rd_we   = r_rd_we;
  assign c_flag          = r_c;
  assign z_flag          = r_z;
  assign retired_cnt     = r_retired;
  assign squashed_cnt    = r_squashed;
  assign o_dbg_state     = r_state;

endmodule
